// File: rtl/sprite_queue.sv
// Sprite entry FIFO between the sprite fetcher and the rasteriser.
// First-word-fall-through head, saturating drop counter, flushed per frame.
module sprite_queue #(
  parameter int DEPTH = 32
) (
  input  logic                       clock,
  input  logic                       fb_resetting,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [7:0]                 enq_id,
  input  logic [15:0]                enq_x,
  input  logic [15:0]                enq_y,
  input  logic [7:0]                 enq_scale,
  input  logic                       sprite_queue_dequeue,
  output logic                       sprite_queue_is_empty,
  output logic [7:0]                 sprite_queue_sprite_id,
  output logic [15:0]                sprite_queue_sprite_x,
  output logic [15:0]                sprite_queue_sprite_y,
  output logic [7:0]                 sprite_queue_sprite_scale,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                overflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    rst_sync;
  logic          rst;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [47:0]   mem [DEPTH];
  logic [47:0]   head;
  logic          full;
  logic          empty;
  logic          do_enq;
  logic          do_deq;

  // Assert immediately, release two edges after fb_resetting drops.
  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) rst_sync <= 2'b11;
    else              rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst = rst_sync[1];

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_enq = enq_valid && !full;
  assign do_deq = sprite_queue_dequeue && !empty;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow_count <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (enq_valid && full && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_enq && !rst)
      mem[wr_ptr] <= {enq_id, enq_x, enq_y, enq_scale};
  end

  assign head = empty ? 48'd0 : mem[rd_ptr];

  assign enq_ready                 = !full;
  assign sprite_queue_is_empty     = empty;
  assign sprite_queue_sprite_id    = head[47:40];
  assign sprite_queue_sprite_x     = head[39:24];
  assign sprite_queue_sprite_y     = head[23:8];
  assign sprite_queue_sprite_scale = head[7:0];

endmodule
